// File: rtl/risc_core_param.sv
// rtl/risc_core_param.sv - parametrised multi-cycle RISC core with WAIT/DECODE/EXEC1/EXEC2/DONE FSM
// Executes one func word per new_func handshake; debug port reads the register file combinationally.
module risc_core_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int PC_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              new_func,
    input  logic [DATA_W+7:0] func,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic [PC_W-1:0]   pc
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DECODE, S_EXEC1, S_EXEC2, S_DONE} state_t;

    localparam logic [3:0] OP_LOAD = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_XOR = 4'h3,
                           OP_MIN  = 4'h4, OP_LDPC = 4'h5, OP_BR = 4'h6, OP_SUB = 4'h7,
                           OP_AND  = 4'h8, OP_OR = 4'h9;

    state_t              r_state, w_next;
    logic [DATA_W+7:0]   r_ir;
    logic [DATA_W-1:0]   r_a, r_g;
    logic [DATA_W-1:0]   r_regs [16];
    logic [DATA_W-1:0]   r_result;
    logic                r_zero, r_err;
    logic [PC_W-1:0]     r_pc;

    logic [3:0]          w_op, w_rx, w_ry;
    logic [DATA_W-1:0]   w_imm, w_rx_val, w_ry_val, w_alu, w_wr_data;
    logic                w_is_alu, w_uses_ry, w_illegal, w_wr_en;

    assign w_op     = r_ir[DATA_W+7:DATA_W+4];
    assign w_rx     = r_ir[DATA_W+3:DATA_W];
    assign w_imm    = r_ir[DATA_W-1:0];
    assign w_ry     = r_ir[DATA_W-1:DATA_W-4];
    assign w_rx_val = r_regs[w_rx];
    assign w_ry_val = r_regs[w_ry];

    assign w_is_alu  = (w_op inside {OP_ADD, OP_XOR, OP_MIN, OP_SUB, OP_AND, OP_OR});
    assign w_uses_ry = w_is_alu || (w_op == OP_MOV);
    assign w_illegal = (w_op > OP_OR) || ({1'b0, w_rx} >= 5'(NUM_REGS))
                    || (w_uses_ry && ({1'b0, w_ry} >= 5'(NUM_REGS)));

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_a + w_ry_val;
            OP_XOR:  w_alu = r_a ^ w_ry_val;
            OP_MIN:  w_alu = (r_a < w_ry_val) ? r_a : w_ry_val;
            OP_SUB:  w_alu = r_a - w_ry_val;
            OP_AND:  w_alu = r_a & w_ry_val;
            OP_OR:   w_alu = r_a | w_ry_val;
            default: w_alu = '0;
        endcase
    end

    // Short ops write on the DECODE exit edge, ALU ops on the EXEC2 exit edge.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = r_g;
        if (r_state == S_EXEC2) begin
            w_wr_en = 1'b1;
        end else if (r_state == S_DECODE && !w_illegal) begin
            case (w_op)
                OP_LOAD: begin w_wr_en = 1'b1; w_wr_data = w_imm;            end
                OP_MOV:  begin w_wr_en = 1'b1; w_wr_data = w_ry_val;         end
                OP_LDPC: begin w_wr_en = 1'b1; w_wr_data = DATA_W'(r_pc);    end
                default: w_wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_WAIT;
            S_WAIT:   if (!start) w_next = S_IDLE;
                      else if (new_func) w_next = S_DECODE;
            S_DECODE: w_next = (w_is_alu && !w_illegal) ? S_EXEC1 : S_DONE;
            S_EXEC1:  w_next = S_EXEC2;
            S_EXEC2:  w_next = S_DONE;
            S_DONE:   w_next = S_WAIT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state inside {S_DECODE, S_EXEC1, S_EXEC2, S_DONE});
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir     <= '0;
            r_a      <= '0;
            r_g      <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
            r_pc     <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == S_WAIT && start && new_func) begin
                r_ir  <= func;
                r_err <= 1'b0;
            end
            if (r_state == S_DECODE) begin
                r_err <= w_illegal;
                r_a   <= w_rx_val;
            end
            if (r_state == S_EXEC1) r_g <= w_alu;
            if (w_wr_en) begin
                r_regs[w_rx] <= w_wr_data;
                r_result     <= w_wr_data;
                r_zero       <= (w_wr_data == '0);
            end
            // A branch with a bad register index keeps pc where it was.
            if (r_state == S_DONE) begin
                if (w_op == OP_BR) begin
                    if (!r_err) r_pc <= w_rx_val[PC_W-1:0];
                end else begin
                    r_pc <= r_pc + 1'b1;
                end
            end
        end
    end

    assign dbg_data = ({1'b0, dbg_addr} < 5'(NUM_REGS)) ? r_regs[dbg_addr] : '0;
    assign result   = r_result;
    assign zero     = r_zero;
    assign err      = r_err;
    assign pc       = r_pc;
endmodule

// File: tb/tb_risc_core_param.sv
// tb/tb_risc_core_param.sv - directed bench running a default core and a 32-bit/PC_W=4 core in lockstep
module tb_risc_core_param;
    logic        clk, reset, start, new_func;
    logic [3:0]  dbg_addr;
    logic [23:0] func0;
    logic [39:0] func1;
    logic [15:0] dbg0, result0;
    logic [31:0] dbg1, result1;
    logic        busy0, done0, err0, zero0, busy1, done1, err1, zero1;
    logic [7:0]  pc0;
    logic [3:0]  pc1;
    int          checks = 0;
    int          errors = 0;
    logic        d_err0, d_err1;

    risc_core_param u0 (
        .clk(clk), .reset(reset), .start(start), .new_func(new_func), .func(func0),
        .dbg_addr(dbg_addr), .dbg_data(dbg0), .busy(busy0), .done(done0), .err(err0),
        .result(result0), .zero(zero0), .pc(pc0)
    );

    risc_core_param #(.DATA_W(32), .NUM_REGS(8), .PC_W(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .new_func(new_func), .func(func1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1), .busy(busy1), .done(done1), .err(err1),
        .result(result1), .zero(zero1), .pc(pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic dbg(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1, input string tag);
        dbg_addr = a;
        #1;
        chk({tag, "_u0"}, 32'(dbg0), e0);
        chk({tag, "_u1"}, dbg1, e1);
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                         input logic [31:0] imm, input bit use_imm);
        func0 = {op, rx, use_imm ? imm[15:0] : {ry, 12'h000}};
        func1 = {op, rx, use_imm ? imm : {ry, 28'h0}};
    endtask

    // Issues one instruction, counts edges from the sample edge back to WAIT and done pulses.
    task automatic run(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                       input logic [31:0] imm, input bit use_imm, input int exp_lat, input string tag);
        int lat, nd0, nd1;
        @(negedge clk);
        drive(op, rx, ry, imm, use_imm);
        new_func = 1'b1;
        @(posedge clk);
        #1 new_func = 1'b0;
        lat = 1; nd0 = 0; nd1 = 0;
        while (busy0 && lat < 20) begin
            if (done0) begin nd0++; d_err0 = err0; end
            if (done1) begin nd1++; d_err1 = err1; end
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done0"}, nd0, 1);
        chk({tag, "_done1"}, nd1, 1);
    endtask

    initial begin
        int lat, nd;
        reset = 1'b1; start = 1'b0; new_func = 1'b0; dbg_addr = '0; func0 = '0; func1 = '0;
        d_err0 = 1'b0; d_err1 = 1'b0;
        #12;
        chk("rst_busy", busy0, 0);   chk("rst_done", done0, 0);  chk("rst_err", err0, 0);
        chk("rst_result", result0, 0); chk("rst_zero", zero0, 1); chk("rst_pc", pc0, 0);
        chk("rst_zero1", zero1, 1);
        @(negedge clk);
        reset = 1'b0; start = 1'b1;

        // reset during EXEC2 of an add
        run(4'h0, 4'd1, 4'd0, 32'd3, 1'b1, 3, "ld_r1");
        chk("pc_pre_rst", pc0, 1);
        @(negedge clk);
        drive(4'h2, 4'd0, 4'd1, 32'd0, 1'b0);
        new_func = 1'b1;
        @(posedge clk); #1 new_func = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy0, 0); chk("abort_pc", pc0, 0); chk("abort_pc1", pc1, 0);
        dbg(4'd0, 0, 0, "abort_r0");
        @(negedge clk);
        reset = 1'b0;

        // default program
        run(4'h0, 4'd0, 4'd0, 32'h10, 1'b1, 3, "ld_r0");
        run(4'h1, 4'd2, 4'd0, 32'h0, 1'b0, 3, "mov_r2");
        dbg(4'd2, 32'h10, 32'h10, "r2_mov");
        run(4'h0, 4'd1, 4'd0, 32'h4, 1'b1, 3, "ld_r1b");
        run(4'h2, 4'd0, 4'd1, 32'h0, 1'b0, 5, "add_r0");
        dbg(4'd0, 32'h14, 32'h14, "r0_add");
        run(4'h3, 4'd2, 4'd0, 32'h0, 1'b0, 5, "xor_r2");
        dbg(4'd2, 32'h4, 32'h4, "r2_xor");
        run(4'h4, 4'd0, 4'd2, 32'h0, 1'b0, 5, "min_r0");
        dbg(4'd0, 32'h4, 32'h4, "r0_min");
        run(4'h5, 4'd5, 4'd0, 32'h0, 1'b0, 3, "ldpc_r5");
        dbg(4'd5, 32'h6, 32'h6, "r5_ldpc");
        chk("ldpc_result", result0, 6); chk("ldpc_zero", zero0, 0); chk("ldpc_pc", pc0, 7);
        run(4'h2, 4'd0, 4'd1, 32'h0, 1'b0, 5, "add_r0b");
        dbg(4'd0, 32'h8, 32'h8, "r0_add8");
        run(4'h2, 4'd2, 4'd0, 32'h0, 1'b0, 5, "add_r2");
        dbg(4'd2, 32'hC, 32'hC, "r2_addc");
        chk("pre_br_pc", pc0, 9);
        run(4'h6, 4'd5, 4'd0, 32'h0, 1'b0, 3, "br_r5");
        chk("br_pc0", pc0, 6); chk("br_pc1", pc1, 6);

        // wrap-around and zero flag
        run(4'h0, 4'd3, 4'd0, 32'hFFFF_FFFF, 1'b1, 3, "ld_r3");
        run(4'h0, 4'd4, 4'd0, 32'h1, 1'b1, 3, "ld_r4");
        run(4'h2, 4'd3, 4'd4, 32'h0, 1'b0, 5, "add_wrap");
        dbg(4'd3, 32'h0, 32'h0, "r3_wrap");
        chk("wrap_zero0", zero0, 1); chk("wrap_zero1", zero1, 1); chk("wrap_res1", result1, 0);
        run(4'h7, 4'd3, 4'd4, 32'h0, 1'b0, 5, "sub_r3");
        dbg(4'd3, 32'hFFFF, 32'hFFFF_FFFF, "r3_sub");
        chk("sub_zero1", zero1, 0); chk("sub_res1", result1, 32'hFFFF_FFFF);
        run(4'h8, 4'd3, 4'd0, 32'h0, 1'b0, 5, "and_r3");
        dbg(4'd3, 32'h8, 32'h8, "r3_and");
        run(4'h9, 4'd3, 4'd1, 32'h0, 1'b0, 5, "or_r3");
        dbg(4'd3, 32'hC, 32'hC, "r3_or");
        chk("or_pc", pc0, 12);

        // illegal instructions
        run(4'hC, 4'd0, 4'd0, 32'h0, 1'b0, 3, "op_c");
        chk("opc_err0", d_err0, 1); chk("opc_err1", d_err1, 1); chk("opc_pc", pc0, 13);
        dbg(4'd0, 32'h8, 32'h8, "r0_keep");
        chk("opc_result", result0, 32'hC);
        run(4'h1, 4'd9, 4'd0, 32'h0, 1'b0, 3, "mov_r9");
        chk("mov9_err", d_err0, 1); chk("mov9_sticky", err0, 1); chk("mov9_pc", pc0, 14);
        run(4'h0, 4'd6, 4'd0, 32'h55, 1'b1, 3, "ld_r6");
        chk("ld6_err", d_err0, 0); chk("ld6_err1", d_err1, 0);
        run(4'h6, 4'd9, 4'd0, 32'h0, 1'b0, 3, "br_r9");
        chk("br9_err", d_err0, 1); chk("br9_pc", pc0, 15); chk("br9_pc1", pc1, 15);
        dbg(4'd9, 32'h0, 32'h0, "dbg_r9");
        run(4'h1, 4'd1, 4'd9, 32'h0, 1'b0, 3, "mov_ry9");
        chk("ry9_err", d_err0, 1); chk("ry9_pc0", pc0, 16); chk("ry9_pc1", pc1, 0);
        dbg(4'd1, 32'h4, 32'h4, "r1_keep");

        // sixteen loads wrap the 4-bit pc back to the same value
        for (int i = 0; i < 16; i++) run(4'h0, 4'd7, 4'd0, 32'(i), 1'b1, 3, "ld_loop");
        chk("loop_pc0", pc0, 32); chk("loop_pc1", pc1, 0);
        dbg(4'd7, 32'hF, 32'hF, "r7_loop");

        // new_func pulsed during EXEC1 is ignored
        @(negedge clk);
        drive(4'h2, 4'd7, 4'd7, 32'h0, 1'b0);
        new_func = 1'b1;
        @(posedge clk); #1 new_func = 1'b0;
        lat = 1; nd = 0;
        while (busy0 && lat < 20) begin
            if (done0) nd++;
            new_func = (lat == 2);
            @(posedge clk);
            #1 lat++;
        end
        new_func = 1'b0;
        chk("nf_lat", lat, 5); chk("nf_done", nd, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("nf_idle", busy0, 0); chk("nf_pc", pc0, 33);
        dbg(4'd7, 32'h1E, 32'h1E, "r7_dbl");

        // start low returns to IDLE and blocks new work
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        drive(4'h0, 4'd0, 4'd0, 32'hAA, 1'b1);
        new_func = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("nostart_busy", busy0, 0);
        dbg(4'd0, 32'h8, 32'h8, "nostart_r0");
        new_func = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
